// File: rtl/wave_generator.sv
// Purpose : waveform core; each clk_div rising edge advances an 8-bit phase and emits
//           one unsigned sample (square, sawtooth, triangle or sine), midscale 0x80.
// Latency : wave/valid/phase update on the clk edge that first samples clk_div high.
//           No backpressure: one sample per strobe; en=0 drops strobes and holds state.
// Ports   : clk, rst (sync, active-low), clk_div (strobe source), en, phase_clr,
//           wave_sel[1:0] (00 sq, 01 saw, 10 tri, 11 sine) -> wave[7:0], valid, phase[7:0]
module wave_generator #(
    parameter int SQ_DUTY = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_div,
    input  logic       en,
    input  logic       phase_clr,
    input  logic [1:0] wave_sel,
    output logic [7:0] wave,
    output logic       valid,
    output logic [7:0] phase
);

    // Nine bits so that SQ_DUTY=256 (always high) is representable.
    localparam logic [8:0] DUTY = 9'(SQ_DUTY);

    logic       clk_div_q;
    logic [1:0] sel_act;
    logic       tick;
    logic [7:0] pn;
    logic [1:0] sel_nxt;
    logic [7:0] wave_nxt;
    logic [5:0] sin_idx;
    logic [6:0] sin_q;

    // Quarter-wave sine ROM: Q[i] = round(127*sin(pi/2*(i+0.5)/64)).
    function automatic logic [6:0] sine_q(input logic [5:0] i);
        logic [6:0] q;
        q = 7'd0;
        case (i)
            6'd0:  q = 7'd2;   6'd1:  q = 7'd5;   6'd2:  q = 7'd8;   6'd3:  q = 7'd11;
            6'd4:  q = 7'd14;  6'd5:  q = 7'd17;  6'd6:  q = 7'd20;  6'd7:  q = 7'd23;
            6'd8:  q = 7'd26;  6'd9:  q = 7'd29;  6'd10: q = 7'd32;  6'd11: q = 7'd35;
            6'd12: q = 7'd38;  6'd13: q = 7'd41;  6'd14: q = 7'd44;  6'd15: q = 7'd47;
            6'd16: q = 7'd50;  6'd17: q = 7'd53;  6'd18: q = 7'd56;  6'd19: q = 7'd58;
            6'd20: q = 7'd61;  6'd21: q = 7'd64;  6'd22: q = 7'd67;  6'd23: q = 7'd69;
            6'd24: q = 7'd72;  6'd25: q = 7'd74;  6'd26: q = 7'd77;  6'd27: q = 7'd79;
            6'd28: q = 7'd82;  6'd29: q = 7'd84;  6'd30: q = 7'd86;  6'd31: q = 7'd89;
            6'd32: q = 7'd91;  6'd33: q = 7'd93;  6'd34: q = 7'd95;  6'd35: q = 7'd97;
            6'd36: q = 7'd99;  6'd37: q = 7'd101; 6'd38: q = 7'd103; 6'd39: q = 7'd105;
            6'd40: q = 7'd106; 6'd41: q = 7'd108; 6'd42: q = 7'd110; 6'd43: q = 7'd111;
            6'd44: q = 7'd113; 6'd45: q = 7'd114; 6'd46: q = 7'd115; 6'd47: q = 7'd117;
            6'd48: q = 7'd118; 6'd49: q = 7'd119; 6'd50: q = 7'd120; 6'd51: q = 7'd121;
            6'd52: q = 7'd122; 6'd53: q = 7'd123; 6'd54: q = 7'd124; 6'd55: q = 7'd124;
            6'd56: q = 7'd125; 6'd57: q = 7'd125; 6'd58: q = 7'd126; 6'd59: q = 7'd126;
            6'd60: q = 7'd127; 6'd61: q = 7'd127; 6'd62: q = 7'd127; 6'd63: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    // One-clk strobe on the divider's rising edge; clk_div_q resets high so a
    // divider that is already high coming out of reset does not fire.
    assign tick = clk_div & ~clk_div_q & en;
    assign pn   = phase + 8'd1;

    // A new wave_sel is adopted only as the phase wraps, so a period never mixes shapes.
    assign sel_nxt = (pn == 8'd0) ? wave_sel : sel_act;

    // Second and fourth quadrants read the ROM mirrored.
    assign sin_idx = pn[6] ? ~pn[5:0] : pn[5:0];
    assign sin_q   = sine_q(sin_idx);

    always_comb begin
        wave_nxt = 8'h00;
        case (sel_nxt)
            2'b00:   wave_nxt = ({1'b0, pn} < DUTY) ? 8'hFF : 8'h00;
            2'b01:   wave_nxt = pn;
            2'b10:   wave_nxt = pn[7] ? {~pn[6:0], 1'b0} : {pn[6:0], 1'b0};
            default: wave_nxt = pn[7] ? (8'd127 - {1'b0, sin_q}) : (8'd128 + {1'b0, sin_q});
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase     <= 8'h00;
            wave      <= 8'h00;
            valid     <= 1'b0;
            clk_div_q <= 1'b1;
            sel_act   <= wave_sel;
        end else begin
            clk_div_q <= clk_div;
            if (phase_clr) begin
                // Restart wins over a coincident strobe; the last sample stays on wave.
                phase   <= 8'h00;
                sel_act <= wave_sel;
                valid   <= 1'b0;
            end else if (tick) begin
                phase <= pn;
                wave  <= wave_nxt;
                valid <= 1'b1;
                if (pn == 8'd0) begin
                    sel_act <= wave_sel;
                end
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_generator.sv
module tb_wave_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_div = 1'b1;
    logic       en = 1'b1;
    logic       phase_clr = 1'b0;
    logic [1:0] wave_sel = 2'b01;
    logic [7:0] wave_a, phase_a, wave_b, phase_b;
    logic       valid_a, valid_b;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    logic prev_valid_a = 1'b0;
    logic prev_valid_b = 1'b0;

    // Scoreboards hold {phase, wave}; a = default duty 128, b = duty 64.
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    // Reference model state.
    logic [7:0] m_phase = 8'h00;
    logic [1:0] m_sel_act = 2'b01;
    logic [7:0] m_wave_a = 8'h00;
    logic [7:0] m_wave_b = 8'h00;

    wave_generator #(.SQ_DUTY(128)) dut_a (
        .clk(clk), .rst(rst), .clk_div(clk_div), .en(en), .phase_clr(phase_clr),
        .wave_sel(wave_sel), .wave(wave_a), .valid(valid_a), .phase(phase_a)
    );

    wave_generator #(.SQ_DUTY(64)) dut_b (
        .clk(clk), .rst(rst), .clk_div(clk_div), .en(en), .phase_clr(phase_clr),
        .wave_sel(wave_sel), .wave(wave_b), .valid(valid_b), .phase(phase_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Expected sample computed from the waveform definitions; sine from real-valued sin().
    function automatic logic [7:0] model_f(input logic [1:0] sel, input logic [7:0] p, input int duty);
        real s;
        int  r;
        logic [7:0] out;
        out = 8'h00;
        case (sel)
            2'b00: out = (int'(p) < duty) ? 8'hFF : 8'h00;
            2'b01: out = p;
            2'b10: out = (p < 8'd128) ? 8'(2 * int'(p)) : 8'(2 * (255 - int'(p)));
            default: begin
                s = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 256.0);
                if (s >= 0.0) begin
                    r = $rtoi(s + 0.5);
                    out = 8'(128 + r);
                end else begin
                    r = $rtoi(-s + 0.5);
                    out = 8'(127 - r);
                end
            end
        endcase
        return out;
    endfunction

    // Output monitors: every valid pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (valid_a) begin
            valid_cnt++;
            checks++;
            if (prev_valid_a) begin
                errors++;
                $display("FAIL valid_width_a: valid high on consecutive clks, required one-clk pulse");
            end
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid_a: phase=%h wave=%h, required no pulse", phase_a, wave_a);
            end else if ({phase_a, wave_a} !== q_a[0]) begin
                errors++;
                $display("FAIL sample_a: got phase=%h wave=%h, required phase=%h wave=%h",
                         phase_a, wave_a, q_a[0][15:8], q_a[0][7:0]);
                void'(q_a.pop_front());
            end else begin
                void'(q_a.pop_front());
            end
        end
        if (valid_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid_b: phase=%h wave=%h, required no pulse", phase_b, wave_b);
            end else if ({phase_b, wave_b} !== q_b[0]) begin
                errors++;
                $display("FAIL sample_b: got phase=%h wave=%h, required phase=%h wave=%h",
                         phase_b, wave_b, q_b[0][15:8], q_b[0][7:0]);
                void'(q_b.pop_front());
            end else begin
                void'(q_b.pop_front());
            end
        end
        prev_valid_a = valid_a;
        prev_valid_b = valid_b;
    end

    // One divider period (3 clks); returns 1 time unit after the last edge.
    task automatic strobe();
        logic [7:0] pn;
        logic [1:0] s;
        @(posedge clk); #1;
        clk_div = 1'b1;
        if (en) begin
            pn = m_phase + 8'd1;
            s  = (pn == 8'd0) ? wave_sel : m_sel_act;
            if (pn == 8'd0) m_sel_act = wave_sel;
            m_phase  = pn;
            m_wave_a = model_f(s, pn, 128);
            m_wave_b = model_f(s, pn, 64);
            q_a.push_back({pn, m_wave_a});
            q_b.push_back({pn, m_wave_b});
        end
        @(posedge clk); #1;
        clk_div = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clear_phase(input logic [1:0] sel);
        @(posedge clk); #1;
        wave_sel  = sel;
        phase_clr = 1'b1;
        @(posedge clk); #1;
        phase_clr = 1'b0;
        m_phase   = 8'h00;
        m_sel_act = sel;
    endtask

    task automatic test_reset();
        rst = 1'b0; clk_div = 1'b1; en = 1'b1; phase_clr = 1'b0; wave_sel = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wave_a, valid_a, phase_a} !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: wave=%h valid=%b phase=%h, required 00/0/00", wave_a, valid_a, phase_a);
        end
        rst = 1'b1;
        m_phase = 8'h00; m_sel_act = 2'b01;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (valid_cnt !== 0 || phase_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_strobe: pulses=%0d phase=%h, required 0/00", valid_cnt, phase_a);
        end
        clk_div = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_saw_wrap();
        int start;
        start = valid_cnt;
        for (int i = 0; i < 256; i++) strobe();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_cnt - start !== 256) begin
            errors++;
            $display("FAIL saw_pulse_count: got %0d, required 256", valid_cnt - start);
        end
        checks++;
        if (phase_a !== 8'h00 || wave_a !== 8'h00) begin
            errors++;
            $display("FAIL saw_wrap: phase=%h wave=%h, required 00/00", phase_a, wave_a);
        end
    endtask

    task automatic test_tri_sine();
        clear_phase(2'b10);
        for (int i = 0; i < 256; i++) begin
            strobe();
            if (m_phase == 8'd127 || m_phase == 8'd128 || m_phase == 8'd255) begin
                checks++;
                if (wave_a !== ((m_phase == 8'd255) ? 8'h00 : 8'hFE)) begin
                    errors++;
                    $display("FAIL tri_point: phase=%h wave=%h, required %h",
                             m_phase, wave_a, (m_phase == 8'd255) ? 8'h00 : 8'hFE);
                end
            end
        end
        clear_phase(2'b11);
        for (int i = 0; i < 256; i++) begin
            strobe();
            if (m_phase == 8'h40 || m_phase == 8'hC0 || m_phase == 8'h00) begin
                checks++;
                if (wave_a !== ((m_phase == 8'h40) ? 8'hFF : (m_phase == 8'hC0) ? 8'h00 : 8'h82)) begin
                    errors++;
                    $display("FAIL sine_point: phase=%h wave=%h", m_phase, wave_a);
                end
            end
        end
    endtask

    task automatic test_sel_change();
        clear_phase(2'b01);
        for (int i = 0; i < 8'h30; i++) strobe();
        wave_sel = 2'b00;
        for (int i = 8'h30; i < 255; i++) strobe();
        checks++;
        if (wave_a !== 8'hFF || phase_a !== 8'hFF) begin
            errors++;
            $display("FAIL sel_saw_end: phase=%h wave=%h, required FF/FF", phase_a, wave_a);
        end
        strobe();
        checks++;
        if (wave_a !== 8'hFF || phase_a !== 8'h00) begin
            errors++;
            $display("FAIL sel_square_start: phase=%h wave=%h, required 00/FF", phase_a, wave_a);
        end
        // Full square period; duty-64 instance checked by its own monitor.
        for (int i = 0; i < 255; i++) begin
            strobe();
            if (m_phase == 8'd63 || m_phase == 8'd64) begin
                checks++;
                if (wave_b !== ((m_phase == 8'd63) ? 8'hFF : 8'h00)) begin
                    errors++;
                    $display("FAIL duty64_edge: phase=%h wave=%h", m_phase, wave_b);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] hold_phase, hold_wave;
        strobe(); strobe(); strobe();
        @(posedge clk); #1;
        clk_div = 1'b1; phase_clr = 1'b1;
        @(posedge clk); #1;
        clk_div = 1'b0; phase_clr = 1'b0;
        m_phase = 8'h00; m_sel_act = wave_sel;
        checks++;
        if (phase_a !== 8'h00 || valid_a !== 1'b0 || wave_a !== m_wave_a) begin
            errors++;
            $display("FAIL clr_with_tick: phase=%h valid=%b wave=%h, required 00/0/%h",
                     phase_a, valid_a, wave_a, m_wave_a);
        end
        repeat (5) strobe();
        hold_phase = m_phase;
        hold_wave  = m_wave_a;
        en = 1'b0;
        repeat (10) strobe();
        checks++;
        if (phase_a !== hold_phase || wave_a !== hold_wave) begin
            errors++;
            $display("FAIL en_hold: phase=%h wave=%h, required %h/%h", phase_a, wave_a, hold_phase, hold_wave);
        end
        en = 1'b1;
        strobe();
        checks++;
        if (phase_a !== hold_phase + 8'd1) begin
            errors++;
            $display("FAIL en_resume: phase=%h, required %h", phase_a, hold_phase + 8'd1);
        end
    endtask

    task automatic test_reset_mid();
        wave_sel = 2'b01;
        repeat (7) strobe();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_phase = 8'h00; m_sel_act = wave_sel;
        checks++;
        if ({wave_a, valid_a, phase_a} !== 17'h0) begin
            errors++;
            $display("FAIL reset_mid: wave=%h valid=%b phase=%h, required 00/0/00", wave_a, valid_a, phase_a);
        end
        strobe();
        checks++;
        if (wave_a !== 8'h01 || phase_a !== 8'h01) begin
            errors++;
            $display("FAIL reset_first_sample: phase=%h wave=%h, required 01/01", phase_a, wave_a);
        end
    endtask

    initial begin
        test_reset();
        test_saw_wrap();
        test_tri_sine();
        test_sel_change();
        test_simultaneous();
        test_reset_mid();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d samples never produced, required 0/0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
